// File: rtl/minterm_pkg.sv
// Shared types and constants for the minterm sweeper.
// State encodings, default input count and named truth tables.
package minterm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int N_VARS_DEF = 3;

  localparam logic [7:0] SOP_1357 = 8'hAA;
  localparam logic [7:0] POS_0246 = 8'hAA;
  localparam logic [7:0] ALL_ZERO = 8'h00;

endpackage

// File: rtl/sweep_counter.sv
// Minterm index plus settle down-counter for the sweeper.
// Ports: clk, rst_n, load, en in; idx, sample, last out.
module sweep_counter #(
  parameter int N_VARS = 3,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  output logic [N_VARS-1:0] idx,
  output logic              sample,
  output logic              last
);

  localparam int CW =
    (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE);
  localparam logic [N_VARS-1:0] IDX_MAX = '1;

  logic [N_VARS-1:0] idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (load) begin
      idx_d = '0;
      cnt_d = CNT_INIT;
    end else if (en) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else if (idx_q != IDX_MAX) begin
        idx_d = idx_q + N_VARS'(1);
        cnt_d = CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign idx    = idx_q;
  assign sample = (cnt_q == '0);
  assign last   = (idx_q == IDX_MAX);

endmodule

// File: rtl/minterm_sweeper.sv
// Clocked truth-table sweeper/checker for small logic functions.
// Ports: clk, rst_n, start, f_in in; vars, busy, done,
// table_out, pass, mismatch_idx out.
// Option: SWEEPER_STOP_ON_FAIL_EN ends the sweep at the first miss.
module minterm_sweeper
  import minterm_pkg::*;
#(
  parameter int N_VARS = N_VARS_DEF,
  parameter int SETTLE = 1,
  parameter logic [2**N_VARS-1:0] EXPECT = SOP_1357
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_VARS-1:0]    vars,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_VARS-1:0] table_out,
  output logic                 pass,
  output logic [N_VARS-1:0]    mismatch_idx
);

  localparam int T = 2**N_VARS;

  state_e            state_q, state_d;
  logic [T-1:0]      table_q, table_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_VARS-1:0] mis_q, mis_d;
  logic              found_q, found_d;

  logic [N_VARS-1:0] idx;
  logic              sample;
  logic              last;
  logic              bit_s;
  logic              diff;
  logic              stop_now;
  logic              load;
  logic              en;

  // X/Z on the function output counts as 0
  assign bit_s = (f_in === 1'b1);
  assign diff  = (bit_s != EXPECT[idx]);

`ifdef SWEEPER_STOP_ON_FAIL_EN
  assign stop_now = (state_q == S_RUN) && sample && diff;
`else
  assign stop_now = 1'b0;
`endif

  assign load = start && (state_q != S_RUN);
  // freeze idx on an early stop so vars shows the failing minterm
  assign en   = (state_q == S_RUN) && !stop_now;

  sweep_counter #(
    .N_VARS (N_VARS),
    .SETTLE (SETTLE)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .en     (en),
    .idx    (idx),
    .sample (sample),
    .last   (last)
  );

  always_comb begin
    state_d = state_q;
    table_d = table_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    mis_d   = mis_q;
    found_d = found_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          table_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          mis_d   = '0;
          found_d = 1'b0;
        end
      end
      S_RUN: begin
        if (sample) begin
          table_d[idx] = bit_s;
          if (diff && !found_q) begin
            mis_d   = idx;
            found_d = 1'b1;
          end
          if (last || stop_now) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (table_d == EXPECT);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mis_q   <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mis_q   <= mis_d;
      found_q <= found_d;
    end
  end

  assign vars         = idx;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign pass         = pass_q;
  assign mismatch_idx = mis_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Self-checking bench for minterm_sweeper.
// Default DUT plus a SETTLE=0 instance.
module tb_minterm_sweeper;
  import minterm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [2:0] vars;
  logic       f_in;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       pass;
  logic [2:0] mis;

  logic       start0;
  logic [2:0] vars0;
  logic       f_in0;
  logic       busy0;
  logic       done0;
  logic [7:0] table0;
  logic       pass0;
  logic [2:0] mis0;

  int mode;

  always_comb begin
    case (mode)
      0: f_in = vars[0];
      1: f_in = 1'b0;
      2: f_in = ~vars[0];
      3: f_in = 1'bx;
      4: f_in = 1'b1;
      5: f_in = vars[1];
      default: f_in = 1'b0;
    endcase
  end

  assign f_in0 = vars0[0];

  minterm_sweeper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vars         (vars),
    .f_in         (f_in),
    .busy         (busy),
    .done         (done),
    .table_out    (table_out),
    .pass         (pass),
    .mismatch_idx (mis)
  );

  minterm_sweeper #(
    .SETTLE (0)
  ) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start0),
    .vars         (vars0),
    .f_in         (f_in0),
    .busy         (busy0),
    .done         (done0),
    .table_out    (table0),
    .pass         (pass0),
    .mismatch_idx (mis0)
  );

  typedef struct {
    int         mode;
    logic [7:0] tbl;
    logic       pas;
    logic [2:0] mis;
    int         lat;
  } vec_t;

  vec_t vecs[6];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic run_sweep(input vec_t v,
                           input int pulse_at);
    vec_t       e;
    int         cyc;
    logic [2:0] prev;
    bit         seq_ok;
    bit         flag_ok;
    mode  = v.mode;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb_q.push_back(v);
    cyc     = 0;
    prev    = vars;
    seq_ok  = (vars == 3'd0);
    flag_ok = (busy && !done && !pass);
    while (!done && cyc < 200) begin
      if (cyc == pulse_at) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (!(vars == prev ||
            int'(vars) == int'(prev) + 1))
        seq_ok = 1'b0;
      prev = vars;
      if (!done && (!busy || pass)) flag_ok = 1'b0;
    end
    e = sb_q.pop_front();
    chk($sformatf("latency m%0d", e.mode), cyc, e.lat);
    chk($sformatf("table m%0d", e.mode), table_out, e.tbl);
    chk($sformatf("pass m%0d", e.mode), pass, e.pas);
    if (!e.pas)
      chk($sformatf("mis_idx m%0d", e.mode), mis, e.mis);
    chk($sformatf("busy_end m%0d", e.mode), busy, 0);
    chk($sformatf("vars_end m%0d", e.mode),
        vars, e.lat / 2 - 1);
    chk($sformatf("vars_seq m%0d", e.mode), seq_ok, 1);
    chk($sformatf("run_flags m%0d", e.mode), flag_ok, 1);
  endtask

  initial begin
    int         cyc;
    bit         seq_ok;
    logic [7:0] held;

`ifdef SWEEPER_STOP_ON_FAIL_EN
    vecs[0] = '{0, 8'hAA, 1'b1, 3'd0, 16};
    vecs[1] = '{1, 8'h00, 1'b0, 3'd1, 4};
    vecs[2] = '{2, 8'h01, 1'b0, 3'd0, 2};
    vecs[3] = '{3, 8'h00, 1'b0, 3'd1, 4};
    vecs[4] = '{4, 8'h01, 1'b0, 3'd0, 2};
    vecs[5] = '{5, 8'h00, 1'b0, 3'd1, 4};
`else
    vecs[0] = '{0, 8'hAA, 1'b1, 3'd0, 16};
    vecs[1] = '{1, 8'h00, 1'b0, 3'd1, 16};
    vecs[2] = '{2, 8'h55, 1'b0, 3'd0, 16};
    vecs[3] = '{3, 8'h00, 1'b0, 3'd1, 16};
    vecs[4] = '{4, 8'hFF, 1'b0, 3'd0, 16};
    vecs[5] = '{5, 8'hCC, 1'b0, 3'd1, 16};
`endif

    rst_n  = 1'b0;
    start  = 1'b0;
    start0 = 1'b0;
    mode   = 0;
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst table", table_out, 0);
    chk("rst pass", pass, 0);
    chk("rst mis", mis, 0);
    chk("rst vars", vars, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_sweep(vecs[i], -1);
    end

    // results held in DONE
    held = table_out;
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", done, 1);
    chk("table_hold", table_out, held);

    // start mid-sweep is ignored
    run_sweep(vecs[0], 5);

    // async reset mid-sweep
    mode  = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst table", table_out, 0);
    chk("arst pass", pass, 0);
    chk("arst mis", mis, 0);
    chk("arst vars", vars, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_sweep(vecs[0], -1);

    // SETTLE=0: first sweep to DONE, then restart from DONE
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("s0 first_lat", cyc, 8);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("s0 restart_done", done0, 0);
    chk("s0 restart_busy", busy0, 1);
    chk("s0 restart_vars", vars0, 0);
    cyc    = 0;
    seq_ok = 1'b1;
    while (!done0 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done0 && int'(vars0) != cyc) seq_ok = 1'b0;
    end
    chk("s0 latency", cyc, 8);
    chk("s0 vars_step", seq_ok, 1);
    chk("s0 table", table0, 8'hAA);
    chk("s0 pass", pass0, 1);
    chk("s0 vars_end", vars0, 7);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
